// File: rtl/proc_pkg.sv
// Shared decode-stage constants, select codes and the skid-buffer state type.
package proc_pkg;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned NUM_SRC_DEF = 3;
  localparam int unsigned SEL_W_DEF   = 2;

  // Select codes for the instruction register-address fields
  localparam logic [1:0] SEL_RM = 2'd0;
  localparam logic [1:0] SEL_RT = 2'd1;
  localparam logic [1:0] SEL_RD = 2'd2;

  // Occupancy of the 2-entry output buffer
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/regaddr_select_pipe_if.sv
// Upstream (fields/select) and downstream (address/error) handshake bundle.
interface regaddr_select_pipe_if #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned SEL_W   = 2
);

  logic [NUM_SRC*ADDR_W-1:0] in_fields;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_valid;
  logic                      in_ready;
  logic [ADDR_W-1:0]         out_addr;
  logic                      out_err;
  logic                      out_valid;
  logic                      out_ready;

  // Producer of fields and consumer of addresses
  modport master (
    output in_fields, in_sel, in_valid, out_ready,
    input  in_ready, out_addr, out_err, out_valid
  );

  // The select pipe itself
  modport slave (
    input  in_fields, in_sel, in_valid, out_ready,
    output in_ready, out_addr, out_err, out_valid
  );

endinterface

// File: rtl/skid_buffer.sv
// Generic WIDTH-bit, 2-entry valid/ready buffer with a registered in_ready.
module skid_buffer
  import proc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             accept_c;
  logic             deliver_c;

  assign accept_c    = in_valid_i && in_ready_q;
  assign deliver_c   = out_valid_q && out_ready_i;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;

  // State and storage registers; handshake flags follow the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  // Next-state and storage steering from accept/deliver events
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept_c) begin
          state_d = ONE;
          main_d  = in_data_i;
        end
      end
      ONE: begin
        if (accept_c && deliver_c) begin
          main_d = in_data_i;
        end else if (accept_c) begin
          state_d = TWO;
          skid_d  = in_data_i;
        end else if (deliver_c) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (deliver_c) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: rtl/regaddr_select_pipe.sv
// Register-address select: picks one of NUM_SRC fields, flags bad selects,
// and registers the result behind a 2-entry skid buffer.
module regaddr_select_pipe
  import proc_pkg::*;
#(
  parameter int unsigned ADDR_W  = REG_ADDR_W,
  parameter int unsigned NUM_SRC = NUM_SRC_DEF,
  parameter int unsigned SEL_W   = SEL_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  regaddr_select_pipe_if.slave  bus
);

  localparam int unsigned ITEM_W = ADDR_W + 1;

  logic [ADDR_W-1:0] sel_addr_c;
  logic              sel_err_c;
  logic [ITEM_W-1:0] item_out;

  // Field mux; a select with no matching field yields addr 0 and err 1
  always_comb begin
    sel_addr_c = '0;
    sel_err_c  = 1'b1;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (bus.in_sel == SEL_W'(i)) begin
        sel_addr_c = bus.in_fields[i*ADDR_W +: ADDR_W];
        sel_err_c  = 1'b0;
      end
    end
  end

  skid_buffer #(
    .WIDTH (ITEM_W)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .in_data_i   ({sel_err_c, sel_addr_c}),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .out_data_o  (item_out),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready)
  );

  assign bus.out_err  = item_out[ADDR_W];
  assign bus.out_addr = item_out[ADDR_W-1:0];

endmodule

// File: tb/tb_regaddr_select_pipe.sv
// Randomized and directed bench for regaddr_select_pipe with a queue model.
module tb_regaddr_select_pipe;
  import proc_pkg::*;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned NUM_SRC = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned F_W     = NUM_SRC * ADDR_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regaddr_select_pipe_if #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) bus ();

  regaddr_select_pipe #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [ADDR_W:0] exp_q[$];
  bit last_acc;

  // Expected {err, addr} from the selection rule
  function automatic logic [ADDR_W:0] ref_item(logic [F_W-1:0] f, int sel);
    if (sel < int'(NUM_SRC)) return {1'b0, f[sel*ADDR_W +: ADDR_W]};
    return {1'b1, {ADDR_W{1'b0}}};
  endfunction

  // One clock: record transfers into the model, return at the falling edge
  task automatic tick();
    bit acc, del;
    acc = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1) && !reset;
    del = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1) && !reset;
    @(posedge clk);
    if (reset) exp_q.delete();
    else begin
      if (del && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ref_item(bus.in_fields, int'(bus.in_sel)));
    end
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic drive(logic v, logic [F_W-1:0] f, int sel);
    bus.in_valid  = v;
    bus.in_fields = f;
    bus.in_sel    = SEL_W'(sel);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, F_W'($urandom), 1);
    bus.out_ready = 1'b1;
    repeat (3) begin
      tick();
      checks += 4;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      if (bus.out_addr !== '0) begin errors++; $display("FAIL reset_out_addr: got %0d want 0", bus.out_addr); end
      if (bus.out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b want 0", bus.out_err); end
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    checks += 2;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_basic_select();
    drive(1'b1, {5'd2, 5'd17, 5'd31}, 1);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks += 3;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", bus.out_valid); end
    if (bus.out_addr !== 5'd17) begin errors++; $display("FAIL basic_addr: got %0d want 17", bus.out_addr); end
    if (bus.out_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", bus.out_err); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_streaming();
    logic [ADDR_W:0] exp_item;
    logic [F_W-1:0] f;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      f = F_W'($urandom);
      exp_item = ref_item(f, i % 3);
      drive(1'b1, f, i % 3);
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
      tick();
      checks += 2;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, bus.out_valid); end
      if ({bus.out_err, bus.out_addr} !== exp_item) begin
        errors++; $display("FAIL stream_item[%0d]: got %h want %h", i, {bus.out_err, bus.out_addr}, exp_item);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, {5'd0, 5'd0, 5'd4}, 0);
    tick();
    drive(1'b1, {5'd0, 5'd0, 5'd9}, 0);
    tick();
    drive(1'b1, {5'd0, 5'd0, 5'd12}, 0);
    repeat (2) begin
      tick();
      checks += 3;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready: got %b want 0", bus.in_ready); end
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b want 1", bus.out_valid); end
      if (bus.out_addr !== 5'd4) begin errors++; $display("FAIL bp_hold_addr: got %0d want 4", bus.out_addr); end
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_addr !== 5'd9) begin errors++; $display("FAIL bp_second: got %0d want 9", bus.out_addr); end
    tick();
    bus.in_valid = 1'b0;
    checks += 2;
    if (bus.out_addr !== 5'd12) begin errors++; $display("FAIL bp_third: got %0d want 12", bus.out_addr); end
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_third_valid: got %b want 1", bus.out_valid); end
    tick();
    checks += 2;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_model_empty: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_bad_select();
    logic [F_W-1:0] f;
    f = F_W'($urandom) | F_W'(1);
    bus.out_ready = 1'b1;
    drive(1'b1, f, 3);
    tick();
    checks += 3;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL badsel_valid: got %b want 1", bus.out_valid); end
    if (bus.out_addr !== '0) begin errors++; $display("FAIL badsel_addr: got %0d want 0", bus.out_addr); end
    if (bus.out_err !== 1'b1) begin errors++; $display("FAIL badsel_err: got %b want 1", bus.out_err); end
    drive(1'b1, f, int'(SEL_RM));
    tick();
    bus.in_valid = 1'b0;
    checks += 2;
    if (bus.out_err !== 1'b0) begin errors++; $display("FAIL goodsel_err: got %b want 0", bus.out_err); end
    if (bus.out_addr !== f[ADDR_W-1:0]) begin errors++; $display("FAIL goodsel_addr: got %0d want %0d", bus.out_addr, f[ADDR_W-1:0]); end
    tick();
  endtask

  task automatic test_reset_stall();
    bus.out_ready = 1'b0;
    drive(1'b1, F_W'($urandom), int'(SEL_RD));
    tick();
    drive(1'b1, F_W'($urandom), int'(SEL_RT));
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rs_full: got %b want 0", bus.in_ready); end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rs_valid_drop: got %b want 0", bus.out_valid); end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rs_in_ready: got %b want 1", bus.in_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rs_stale[%0d]: got %b want 0", i, bus.out_valid); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if (!(bus.in_valid && !last_acc)) begin
        drive(1'b0, F_W'($urandom), int'($urandom_range(0, 3)));
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
      checks += 2;
      if (bus.out_valid !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL rand_valid[%0d]: got %b want %b", n, bus.out_valid, exp_q.size() != 0);
      end
      if (bus.in_ready !== (exp_q.size() < 2)) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b want %b", n, bus.in_ready, exp_q.size() < 2);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if ({bus.out_err, bus.out_addr} !== exp_q[0]) begin
          errors++; $display("FAIL rand_item[%0d]: got %h want %h", n, {bus.out_err, bus.out_addr}, exp_q[0]);
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    checks += 2;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain_model: got %0d want 0", exp_q.size()); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rand_drain_valid: got %b want 0", bus.out_valid); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_fields = '0;
    bus.in_sel    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic_select();
    test_streaming();
    test_backpressure();
    test_bad_select();
    test_reset_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regaddr_select_pipe.md
Name: regaddr_select_pipe

Overview:
Parametrised, pipelined successor to the decoder-stage register-address 2:1 select. It chooses one of NUM_SRC instruction register-address fields, such as Rm/Rt/Rd, using a select code. The result is registered in one stage behind a valid/ready handshake with a 2-entry skid buffer, so decode can stall without combinational ready paths. An out-of-range select raises a defined error flag instead of driving X.

Parameters:
ADDR_W, 5, width of each register-address field
NUM_SRC, 3, number of candidate address fields (min 2)
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_SRC

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_fields  input  NUM_SRC*ADDR_W  packed candidate fields; field i at bits [i*ADDR_W +: ADDR_W]
in_sel  input  SEL_W  field index
in_valid  input  1  upstream presents fields/sel
in_ready  output  1  block can accept this cycle (registered)
out_addr  output  ADDR_W  selected register address
out_err  output  1  sel was >= NUM_SRC for this item
out_valid  output  1  out_addr/out_err valid
out_ready  input  1  downstream accepts

Behaviour:
- Single clock. Reset is synchronous and active-high.
- Reset values: out_valid=0, out_addr=0, out_err=0, in_ready=0 while reset is high; in_ready=1 from the first cycle after reset deasserts.
- Accept when in_valid && in_ready. Deliver when out_valid && out_ready.
- Selection: if in_sel < NUM_SRC, addr = field[in_sel] and err = 0. Otherwise addr = 0 and err = 1. The item is still transferred; it is never dropped.
- Latency: an item accepted at edge N is visible on out_* after edge N (1 cycle) when the output stage is free.
- Storage: main register (drives out_*) and skid register. States:
  - EMPTY: main and skid invalid.
  - ONE: main valid.
  - TWO: main and skid valid.
- Transitions:
  - EMPTY: accept -> ONE.
  - ONE:
    - accept & deliver -> ONE, main gets the new item.
    - accept & !deliver -> TWO, skid gets the new item.
    - !accept & deliver -> EMPTY.
    - otherwise hold.
  - TWO: in_ready=0, so no accept.
    - deliver -> ONE, main gets skid.
    - otherwise hold.
- in_ready = (state != TWO), taken from a register. It never depends combinationally on out_ready.
- Full throughput: with out_ready held high, one item per cycle, with no bubbles.
- Order is strictly preserved. Outputs stay stable while out_valid && !out_ready.
- in_valid and in_sel are ignored when in_ready=0. Upstream must hold in_fields and in_sel until accepted.
- Reset mid-operation: both entries are discarded, state goes to EMPTY, and out_valid drops to 0 in the cycle following the reset edge.
- Simultaneous accept+deliver in state ONE counts as a pass-through: net occupancy is unchanged.

Decomposition:
- Shared package proc_pkg: REG_ADDR_W=5, the select-code constants (SEL_RM=0, SEL_RT=1, SEL_RD=2), and the state enum {EMPTY, ONE, TWO}.
- One natural sub-module: skid_buffer, a generic WIDTH-bit 2-entry valid/ready buffer. It is instantiated with WIDTH=ADDR_W+1 to carry {err, addr}.
- The selection logic stays in the top level.

Test Plan:
- Reset: hold reset 3 cycles with in_valid=1 -> out_valid=0, out_addr=0, out_err=0, in_ready=0 during reset; in_ready=1 the cycle after release.
- Basic select: fields {5'd2,5'd17,5'd31}, sel=1, out_ready=1 -> one cycle later out_addr=17, out_err=0, out_valid=1 for exactly 1 cycle.
- Streaming: 8 back-to-back items with sel cycling 0,1,2, out_ready=1 -> 8 outputs on 8 consecutive cycles, in order, no gaps, and in_ready stays 1.
- Backpressure: out_ready=0 while sending 3 items (addrs 4, 9, 12) -> first two accepted and third stalls (in_ready=0 in TWO); out_addr holds 4. Raise out_ready -> 4, 9, 12 delivered in order and nothing lost.
- Bad select: sel=3 with NUM_SRC=3 -> out_addr=0, out_err=1, item delivered normally; the next item with sel=0 gives out_err=0.
- Reset mid-stall: in state TWO, assert reset for 1 cycle -> out_valid=0 next cycle, no stale items emerge afterwards, in_ready=1 after release.
